// File: rtl/if_fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : if_fetch_unit_pkg
// Brief    : Shared types for the instruction fetch stage: exception causes,
//            fetch FSM states and the reference fetch-queue entry layout.
// Revision : 1.0 - initial parametrised fetch stage
//------------------------------------------------------------------------------
`default_nettype none

package if_fetch_unit_pkg;

  // Exception cause codes carried with a fetch-queue entry
  typedef enum logic [3:0] {
    MISALIGNED_FETCH   = 4'd0,
    INSTR_ACCESS_FAULT = 4'd1
  } exc_cause_t;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Widths of the default configuration (40-bit PC, 32-bit instruction)
  localparam int unsigned C_FQ_ADDR_W = 40;
  localparam int unsigned C_FQ_INST_W = 32;

  // Fetch-queue entry layout for the default configuration; the top builds
  // an equivalent parametrised entry when ADDR_W/INST_W are overridden.
  typedef struct packed {
    logic [C_FQ_ADDR_W-1:0] pc;
    logic [C_FQ_INST_W-1:0] inst;
    logic                   ex_valid;
    exc_cause_t             ex_cause;
  } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_fetch_queue.sv
//------------------------------------------------------------------------------
// Module   : fetch_queue
// Brief    : Parametrised FIFO between fetch and decode. Flush has priority
//            over push/pop; push while full is accepted only with a pop.
//            Head data is read combinationally from storage.
// Revision : 1.0 - initial version
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointer/count: flush empties the queue, otherwise apply push/pop
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail; contents need no reset
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : if_fetch_unit
// Brief    : Fetch stage: sequential PC generation, commit redirects, a single
//            outstanding I-cache request with credit-based flow control into
//            a fetch queue, misaligned-fetch and access-fault exceptions.
//            Optional performance counters when IF_FETCH_PERF_EN is defined.
// Revision : 1.0 - initial parametrised fetch stage
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 40,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h100,
  parameter int unsigned       FQ_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              icache_req_valid_o,
  input  logic              icache_req_ready_i,
  output logic [ADDR_W-1:0] icache_req_vaddr_o,
  input  logic              icache_resp_valid_i,
  input  logic [INST_W-1:0] icache_resp_data_i,
  input  logic              icache_resp_xcpt_i,
  output logic              fetch_valid_o,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic [INST_W-1:0] fetch_inst_o,
  output logic              fetch_ex_valid_o,
  output exc_cause_t        fetch_ex_cause_o,
  output logic [ADDR_W-1:0] fetch_ex_origin_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_req_cnt_o,
  output logic [31:0]       perf_fq_full_cyc_o,
  output logic [31:0]       perf_drop_cnt_o
`endif
);

  localparam int unsigned CNT_W   = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INST_W + 1 + $bits(exc_cause_t);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              ex_valid;
    exc_cause_t        ex_cause;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              halted_q, halted_d;

  entry_t            push_entry;
  entry_t            head_entry;
  logic              fq_push, fq_pop, fq_full, fq_empty;
  logic [CNT_W-1:0]  fq_count;
  logic [CNT_W:0]    occupancy;
  logic              outstanding, credit, aligned, resp_in_wait, issue_slot;
  logic              req_valid, req_fire;

  // Occupancy counts the in-flight response so every response has a slot
  assign outstanding  = (state_q != IDLE);
  assign occupancy    = {1'b0, fq_count} + {{CNT_W{1'b0}}, outstanding};
  assign credit       = !fq_full && (occupancy < (CNT_W+1)'(FQ_DEPTH));
  assign aligned      = (pc_q[1:0] == 2'b00);
  assign resp_in_wait = (state_q == WAIT) && icache_resp_valid_i;
  // A request may go out from IDLE, or back-to-back with a clean response
  assign issue_slot   = (state_q == IDLE) || (resp_in_wait && !icache_resp_xcpt_i);
  assign req_valid    = rstn_i && issue_slot && !redirect_valid_i && aligned &&
                        !halted_q && credit;
  assign req_fire     = req_valid && icache_req_ready_i;

  assign icache_req_valid_o = req_valid;
  assign icache_req_vaddr_o = req_valid ? pc_q : '0;

  // Select the entry pushed this cycle: a response, or a misaligned-PC trap
  always_comb begin
    fq_push    = 1'b0;
    push_entry = '0;
    if (!redirect_valid_i) begin
      if (resp_in_wait) begin
        fq_push             = 1'b1;
        push_entry.pc       = req_pc_q;
        push_entry.inst     = icache_resp_data_i;
        push_entry.ex_valid = icache_resp_xcpt_i;
        push_entry.ex_cause = INSTR_ACCESS_FAULT;
      end else if ((state_q == IDLE) && !aligned && !halted_q && credit) begin
        fq_push             = 1'b1;
        push_entry.pc       = pc_q;
        push_entry.ex_valid = 1'b1;
        push_entry.ex_cause = MISALIGNED_FETCH;
      end
    end
  end

  // Next-state logic for the sequencer, PC and halt flag
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    halted_d = halted_q;
    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i;
      halted_d = 1'b0;
      // An in-flight response must be swallowed unless it lands right now
      state_d  = (outstanding && !icache_resp_valid_i) ? DROP : IDLE;
    end else begin
      case (state_q)
        IDLE: if (fq_push) halted_d = 1'b1;
        WAIT: if (icache_resp_valid_i) begin
                state_d = IDLE;
                if (icache_resp_xcpt_i) halted_d = 1'b1;
              end
        DROP: if (icache_resp_valid_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (req_fire) begin
        state_d  = WAIT;
        req_pc_d = pc_q;
        pc_d     = pc_q + ADDR_W'(4);
      end
    end
  end

  // Sequencer registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      halted_q <= halted_d;
    end
  end

  // A pop in the redirect cycle is void: the flush already discards the head
  assign fq_pop = fetch_valid_o && fetch_ready_i && !redirect_valid_i;

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (redirect_valid_i),
    .push_i  (fq_push),
    .data_i  (push_entry),
    .pop_i   (fq_pop),
    .data_o  (head_entry),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

  assign fetch_valid_o     = !fq_empty;
  assign fetch_pc_o        = fetch_valid_o ? head_entry.pc : '0;
  assign fetch_inst_o      = fetch_valid_o ? head_entry.inst : '0;
  assign fetch_ex_valid_o  = fetch_valid_o && head_entry.ex_valid;
  assign fetch_ex_cause_o  = fetch_ex_valid_o ? head_entry.ex_cause : MISALIGNED_FETCH;
  assign fetch_ex_origin_o = fetch_ex_valid_o ? head_entry.pc : '0;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_req_q, perf_req_d;
  logic [31:0] perf_full_q, perf_full_d;
  logic [31:0] perf_drop_q, perf_drop_d;

  // Saturating event counters; redirects leave them untouched
  always_comb begin
    perf_req_d  = perf_req_q;
    perf_full_d = perf_full_q;
    perf_drop_d = perf_drop_q;
    if (req_fire && (perf_req_q != '1)) perf_req_d = perf_req_q + 32'd1;
    if ((occupancy == (CNT_W+1)'(FQ_DEPTH)) && (perf_full_q != '1))
      perf_full_d = perf_full_q + 32'd1;
    if ((state_q == DROP) && icache_resp_valid_i && (perf_drop_q != '1))
      perf_drop_d = perf_drop_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_req_q  <= '0;
      perf_full_q <= '0;
      perf_drop_q <= '0;
    end else begin
      perf_req_q  <= perf_req_d;
      perf_full_q <= perf_full_d;
      perf_drop_q <= perf_drop_d;
    end
  end

  assign perf_req_cnt_o     = perf_req_q;
  assign perf_fq_full_cyc_o = perf_full_q;
  assign perf_drop_cnt_o    = perf_drop_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench for if_fetch_unit with a behavioural model,
//            an I-cache responder, directed scenarios and random traffic.
// Revision : 1.0 - initial version
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int ADDR_W   = 40;
  localparam int INST_W   = 32;
  localparam int FQ_DEPTH = 4;
  localparam logic [ADDR_W-1:0] NO_FAULT = 40'hFF_FFFF_FFFF;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              redirect_valid_i = 1'b0;
  logic [ADDR_W-1:0] redirect_pc_i = '0;
  logic              icache_req_valid_o;
  logic              icache_req_ready_i = 1'b0;
  logic [ADDR_W-1:0] icache_req_vaddr_o;
  logic              icache_resp_valid_i = 1'b0;
  logic [INST_W-1:0] icache_resp_data_i = '0;
  logic              icache_resp_xcpt_i = 1'b0;
  logic              fetch_valid_o;
  logic              fetch_ready_i = 1'b0;
  logic [ADDR_W-1:0] fetch_pc_o;
  logic [INST_W-1:0] fetch_inst_o;
  logic              fetch_ex_valid_o;
  exc_cause_t        fetch_ex_cause_o;
  logic [ADDR_W-1:0] fetch_ex_origin_o;

  if_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .RESET_PC (40'h100),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .redirect_valid_i    (redirect_valid_i),
    .redirect_pc_i       (redirect_pc_i),
    .icache_req_valid_o  (icache_req_valid_o),
    .icache_req_ready_i  (icache_req_ready_i),
    .icache_req_vaddr_o  (icache_req_vaddr_o),
    .icache_resp_valid_i (icache_resp_valid_i),
    .icache_resp_data_i  (icache_resp_data_i),
    .icache_resp_xcpt_i  (icache_resp_xcpt_i),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_ready_i       (fetch_ready_i),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_inst_o        (fetch_inst_o),
    .fetch_ex_valid_o    (fetch_ex_valid_o),
    .fetch_ex_cause_o    (fetch_ex_cause_o),
    .fetch_ex_origin_o   (fetch_ex_origin_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              ex;
    exc_cause_t        cause;
  } ent_t;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              ex;
    exc_cause_t        cause;
    logic [ADDR_W-1:0] origin;
  } obs_t;

  // Behavioural model state
  ent_t              m_q[$];
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_req_pc;
  logic              m_halted;
  logic              m_out;
  logic              m_drop;

  // I-cache responder controls
  int                lat_cnt;
  int                lat_sel;
  logic [ADDR_W-1:0] fault_pc;
  logic              xcpt_rand_en;

  // Observations for directed checks
  obs_t              log_q[$];
  logic              obs_req_valid;
  logic [ADDR_W-1:0] obs_vaddr;
  logic              obs_fire;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = 40'h100;
    m_req_pc = '0;
    m_halted = 1'b0;
    m_out    = 1'b0;
    m_drop   = 1'b0;
    lat_cnt  = 0;
  endtask

  task automatic do_reset();
    rstn_i              = 1'b0;
    redirect_valid_i    = 1'b0;
    icache_resp_valid_i = 1'b0;
    icache_resp_xcpt_i  = 1'b0;
    model_reset();
    @(negedge clk_i);
    chk("rst_req_valid", 64'(icache_req_valid_o), 64'd0);
    chk("rst_vaddr", 64'(icache_req_vaddr_o), 64'd0);
    chk("rst_fetch_valid", 64'(fetch_valid_o), 64'd0);
    chk("rst_ex_valid", 64'(fetch_ex_valid_o), 64'd0);
    chk("rst_pc", 64'(fetch_pc_o), 64'd0);
    chk("rst_inst", 64'(fetch_inst_o), 64'd0);
    chk("rst_origin", 64'(fetch_ex_origin_o), 64'd0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  // One clock cycle: drive cache response, compare against model, advance model
  task automatic step();
    logic resp_now, credit, exp_req, fire, popped, was_drop;
    ent_t e;
    resp_now = m_out && (lat_cnt == 1);
    icache_resp_valid_i = resp_now;
    icache_resp_data_i  = resp_now ? INST_W'($urandom) : '0;
    icache_resp_xcpt_i  = resp_now && ((m_req_pc == fault_pc) ||
                          (xcpt_rand_en && ($urandom_range(0, 29) == 0)));
    credit  = (m_q.size() + int'(m_out)) < FQ_DEPTH;
    exp_req = !redirect_valid_i && (m_pc[1:0] == 2'b00) && !m_halted && credit &&
              (!m_out || (resp_now && !m_drop && !icache_resp_xcpt_i));

    @(negedge clk_i);
    obs_req_valid = icache_req_valid_o;
    obs_vaddr     = icache_req_vaddr_o;
    obs_fire      = icache_req_valid_o && icache_req_ready_i;
    if (fetch_valid_o && fetch_ready_i && !redirect_valid_i)
      log_q.push_back('{fetch_pc_o, fetch_ex_valid_o, fetch_ex_cause_o, fetch_ex_origin_o});
    chk("req_valid", 64'(icache_req_valid_o), 64'(exp_req));
    if (exp_req) chk("req_vaddr", 64'(icache_req_vaddr_o), 64'(m_pc));
    chk("fetch_valid", 64'(fetch_valid_o), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("fetch_pc", 64'(fetch_pc_o), 64'(m_q[0].pc));
      chk("fetch_inst", 64'(fetch_inst_o), 64'(m_q[0].inst));
      chk("fetch_ex_valid", 64'(fetch_ex_valid_o), 64'(m_q[0].ex));
      if (m_q[0].ex) begin
        chk("fetch_ex_cause", 64'(fetch_ex_cause_o), 64'(m_q[0].cause));
        chk("fetch_ex_origin", 64'(fetch_ex_origin_o), 64'(m_q[0].pc));
      end
    end

    @(posedge clk_i);
    fire     = exp_req && icache_req_ready_i;
    popped   = (m_q.size() != 0) && fetch_ready_i;
    was_drop = m_drop;
    if (redirect_valid_i) begin
      m_q.delete();
      m_pc     = redirect_pc_i;
      m_halted = 1'b0;
      if (m_out && !resp_now) m_drop = 1'b1;
      else begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
    end else begin
      if (popped) void'(m_q.pop_front());
      if (resp_now) begin
        if (!was_drop) begin
          e = '{m_req_pc, icache_resp_data_i, icache_resp_xcpt_i, INSTR_ACCESS_FAULT};
          m_q.push_back(e);
          if (icache_resp_xcpt_i) m_halted = 1'b1;
        end
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (!m_out && (m_pc[1:0] != 2'b00) && !m_halted && credit) begin
        e = '{m_pc, '0, 1'b1, MISALIGNED_FETCH};
        m_q.push_back(e);
        m_halted = 1'b1;
      end
      if (fire) begin
        m_out    = 1'b1;
        m_req_pc = m_pc;
        m_pc     = m_pc + 40'd4;
      end
    end
    if (resp_now) lat_cnt = 0;
    if (fire) lat_cnt = (lat_sel > 0) ? lat_sel : int'($urandom_range(1, 4));
    else if (lat_cnt > 1) lat_cnt--;
    #1;
  endtask

  initial begin
    int n;
    logic found;
    lat_sel      = 1;
    fault_pc     = NO_FAULT;
    xcpt_rand_en = 1'b0;

    // Sequential fetch with 1-cycle cache
    do_reset();
    icache_req_ready_i = 1'b1;
    fetch_ready_i      = 1'b1;
    log_q.delete();
    repeat (8) step();
    chk("A_count", 64'(log_q.size() >= 3), 64'd1);
    if (log_q.size() >= 3) begin
      chk("A_pc0", 64'(log_q[0].pc), 64'h100);
      chk("A_pc1", 64'(log_q[1].pc), 64'h104);
      chk("A_pc2", 64'(log_q[2].pc), 64'h108);
      chk("A_ex", 64'({log_q[0].ex, log_q[1].ex, log_q[2].ex}), 64'd0);
    end

    // Credit limit with decode stalled
    do_reset();
    fetch_ready_i = 1'b0;
    n = 0;
    repeat (12) begin
      step();
      if (obs_fire) n++;
    end
    chk("B_accepted", 64'(n), 64'd4);
    chk("B_req_stopped", 64'(obs_req_valid), 64'd0);
    fetch_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (obs_req_valid) found = 1'b1;
    end
    chk("B_resume_seen", 64'(found), 64'd1);
    chk("B_resume_vaddr", 64'(obs_vaddr), 64'h110);

    // Redirect while a request is outstanding
    do_reset();
    lat_sel = 4;
    step();
    chk("C_first_fire", 64'(obs_fire), 64'd1);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 40'h2000;
    log_q.delete();
    step();
    redirect_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (obs_req_valid && !found) begin
        found = 1'b1;
        chk("C_next_vaddr", 64'(obs_vaddr), 64'h2000);
      end
    end
    chk("C_req_seen", 64'(found), 64'd1);
    chk("C_first_entry_pc", 64'(log_q.size() != 0 ? log_q[0].pc : '0), 64'h2000);

    // Misaligned redirect target
    lat_sel = 1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 40'h2002;
    log_q.delete();
    step();
    redirect_valid_i = 1'b0;
    n = 0;
    repeat (20) begin
      step();
      if (obs_req_valid) n++;
    end
    chk("D_no_requests", 64'(n), 64'd0);
    chk("D_entries", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      chk("D_ex", 64'(log_q[0].ex), 64'd1);
      chk("D_cause", 64'(log_q[0].cause), 64'(MISALIGNED_FETCH));
      chk("D_origin", 64'(log_q[0].origin), 64'h2002);
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 40'h3000;
    step();
    redirect_valid_i = 1'b0;
    step();
    chk("D_resume_vaddr", 64'(obs_vaddr), 64'h3000);

    // Access fault on the second fetch
    do_reset();
    fault_pc = 40'h104;
    log_q.delete();
    n = 0;
    repeat (15) begin
      step();
      if (obs_fire) n++;
    end
    chk("E_fires", 64'(n), 64'd2);
    chk("E_entries", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("E_pc0", 64'(log_q[0].pc), 64'h100);
      chk("E_ex0", 64'(log_q[0].ex), 64'd0);
      chk("E_ex1", 64'(log_q[1].ex), 64'd1);
      chk("E_cause1", 64'(log_q[1].cause), 64'(INSTR_ACCESS_FAULT));
      chk("E_origin1", 64'(log_q[1].origin), 64'h104);
    end
    fault_pc = NO_FAULT;

    // Request held while the cache is not ready
    do_reset();
    lat_sel = 2;
    icache_req_ready_i = 1'b0;
    repeat (5) begin
      step();
      chk("F_held_valid", 64'(obs_req_valid), 64'd1);
      chk("F_held_vaddr", 64'(obs_vaddr), 64'h100);
    end
    icache_req_ready_i = 1'b1;
    step();
    chk("F_handshake", 64'(obs_fire), 64'd1);
    icache_req_ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (obs_req_valid) found = 1'b1;
    end
    chk("F_next_seen", 64'(found), 64'd1);
    chk("F_next_vaddr", 64'(obs_vaddr), 64'h104);

    // Random traffic against the model
    do_reset();
    lat_sel      = 0;
    xcpt_rand_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int sel;
      redirect_valid_i   = ($urandom_range(0, 39) == 0);
      sel                = int'($urandom_range(0, 9));
      if (sel == 0)      redirect_pc_i = {8'($urandom), 30'($urandom), 2'($urandom_range(1, 3))};
      else if (sel == 1) redirect_pc_i = 40'hFF_FFFF_FFF8;
      else               redirect_pc_i = {8'($urandom), 30'($urandom), 2'b00};
      icache_req_ready_i = ($urandom_range(0, 9) < 7);
      fetch_ready_i      = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Parametrised fetch stage and successor to the fixed-width single-entry fetch front end. It generates sequential PCs and handles redirects from commit. It issues I-cache requests with a valid/ready handshake, keeps at most one request outstanding, and buffers responses in a FIFO (fetch queue) of depth FQ_DEPTH toward decode. It detects misaligned fetch and emits a real exception only on misaligned PCs, rather than flagging one on every fetch.

Parameters:
ADDR_W, 40, virtual address / PC width
INST_W, 32, instruction width
RESET_PC, 40'h100, PC loaded on reset
FQ_DEPTH, 4, fetch queue entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous, active-low reset
redirect_valid_i  in  1  commit redirect (highest priority)
redirect_pc_i  in  ADDR_W  redirect target
icache_req_valid_o  out  1  request valid
icache_req_ready_i  in  1  I-cache accepts request
icache_req_vaddr_o  out  ADDR_W  request address
icache_resp_valid_i  in  1  response valid (one per accepted request)
icache_resp_data_i  in  INST_W  instruction
icache_resp_xcpt_i  in  1  access fault on the fetch
fetch_valid_o  out  1  head entry of the queue valid
fetch_ready_i  in  1  decode consumes the head entry
fetch_pc_o  out  ADDR_W  PC of head entry
fetch_inst_o  out  INST_W  instruction of head entry
fetch_ex_valid_o  out  1  head entry carries an exception
fetch_ex_cause_o  out  exc_cause_t  MISALIGNED_FETCH or INSTR_ACCESS_FAULT
fetch_ex_origin_o  out  ADDR_W  faulting PC

Behaviour:
- Reset: pc=RESET_PC, FSM=IDLE, queue empty, halted=0.
- Reset outputs: icache_req_valid_o=0, fetch_valid_o=0, fetch_ex_valid_o=0, all data outputs 0.
- Credit rule: occupancy = queue count + outstanding (0/1). A request is only started when occupancy < FQ_DEPTH, so a response always has a free entry.
- IDLE:
  - Misaligned PC (pc[1:0]!=0): no request issued. When a credit is free, push an entry {pc, inst=0, ex MISALIGNED_FETCH, origin=pc} and set halted=1.
  - Aligned PC, not halted, credit free: drive req_valid=1 with vaddr=pc and hold both stable until ready is seen.
  - On req_valid & req_ready: move to WAIT, pc += 4 (modulo 2^ADDR_W, so the PC wraps).
- WAIT: on resp_valid, push {req_pc, data, ex=resp_xcpt with cause INSTR_ACCESS_FAULT} and return to IDLE.
  - A fault response also sets halted=1.
  - A new request can be issued in the same cycle as the response is accepted (back-to-back fetch).
- DROP: entered on a redirect while a request is outstanding. The pending response is consumed and discarded, then the FSM goes to IDLE.
- Redirect (any state):
  - Flush the queue, pc=redirect_pc_i, halted=0.
  - req_valid is forced to 0 in the redirect cycle.
  - In that cycle, a request handshake is ignored, any push is suppressed, and any pop is void.
  - From WAIT, or with a same-cycle accepted request, go to DROP. If the response arrives in that same redirect cycle, go to IDLE instead.
- Queue:
  - Push and pop in the same cycle are allowed even when the queue is full, because the credit rule guarantees the pushed entry has space.
  - Head output is combinational from storage, so data is visible the cycle after the push.
  - Pop when fetch_valid_o & fetch_ready_i.
- Latency: request accepted at cycle N, response at N+k, entry visible at fetch_valid_o at N+k+1.

Optional Feature:
IF_FETCH_PERF_EN:
- Defined: adds outputs perf_req_cnt_o[31:0] (accepted requests), perf_fq_full_cyc_o[31:0] (cycles occupancy==FQ_DEPTH) and perf_drop_cnt_o[31:0] (responses discarded in DROP).
  - The counters reset to 0, saturate at all-ones, and are not cleared by a redirect.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- drac_pkg additions: exc_cause_t values MISALIGNED_FETCH and INSTR_ACCESS_FAULT; typedef fetch_state_t {IDLE, WAIT, DROP}; struct fq_entry_t {pc, inst, ex_valid, ex_cause}.
- Sub-module fetch_queue: parametrised FIFO (WIDTH, DEPTH) with flush_i, push/pop, full/empty and count outputs.

Test Plan:
- Reset, ready=1, 1-cycle response, fetch_ready=1 -> fetch_pc_o sequence 0x100, 0x104, 0x108, no exceptions.
- fetch_ready=0 with FQ_DEPTH=4 -> exactly 4 requests accepted, then req_valid=0. Raise ready -> requests resume at 0x110.
- Redirect to 0x2000 while in WAIT, response arrives 3 cycles later -> response dropped, queue flushed, next request vaddr 0x2000.
- Redirect to 0x2002 -> no request issued; one entry with ex MISALIGNED_FETCH, origin 0x2002; fetch halted until the next redirect.
- resp_xcpt=1 at PC 0x104 -> entry ex INSTR_ACCESS_FAULT, origin 0x104; no further requests.
- icache_req_ready_i low for 5 cycles -> vaddr stable and valid held; a single handshake advances the PC by 4.
